// File: rtl/kb_pkg.sv
// Shared constants and types for the keyboard event front end.
//   - KC_*     : {extend, scancode} constants for the default key map.
//   - EVT_*    : bit positions inside a queued event word {key, press, repeat}.
//   - rpt_state_e : auto-repeat state machine encoding.
//   - key_width() : width of a key index for a given number of keys.
package kb_pkg;

   localparam logic [8:0] KC_W     = 9'h01D;
   localparam logic [8:0] KC_A     = 9'h01C;
   localparam logic [8:0] KC_S     = 9'h01B;
   localparam logic [8:0] KC_D     = 9'h023;
   localparam logic [8:0] KC_ENTER = 9'h05A;

   // Event word layout: {key, press, repeat}, key in the upper bits.
   localparam int unsigned EVT_REPEAT_BIT = 0;
   localparam int unsigned EVT_PRESS_BIT  = 1;
   localparam int unsigned EVT_KEY_LSB    = 2;

   typedef enum logic [1:0] {
      StIdle,
      StDelay,
      StPeriod
   } rpt_state_e;

   function automatic int unsigned key_width(int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/kb_event_fifo.sv
// Synchronous first-word-fall-through FIFO.
//   clk, rst   : clock, asynchronous active-high reset
//   push       : write push_data (accepted when not full, or when popping)
//   pop        : discard head (ignored when empty)
//   head       : current head word, valid while !empty
//   count      : number of stored words
//   full/empty : status flags
module kb_event_fifo #(
   parameter int unsigned WIDTH = 5,
   parameter int unsigned DEPTH = 8,
   localparam int unsigned AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic [AW:0]      count,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_q, rd_q;
   logic             do_push, do_pop;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign count   = wr_q - rd_q;
   assign empty   = (wr_q == rd_q);
   assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign head    = mem[rd_q[AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + 1'b1;
         if (do_pop)  rd_q <= rd_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_q[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/kb_event_unit.sv
// Keyboard front end: maps scancodes to key indices, tracks held keys,
// auto-repeats the most recently pressed key and queues events.
//   clk, rst               : clock, asynchronous active-high reset
//   code_valid/code/code_break : one-cycle make/break code from the decoder
//   repeat_en              : enables auto-repeat generation
//   evt_ready              : consumer accepts head event
//   evt_valid/evt_key/evt_press/evt_repeat : head event (zero when empty)
//   held                   : held-key bitmap
//   fifo_count             : queued events
//   overflow / ovf_clr     : sticky dropped-event flag and its clear
module kb_event_unit import kb_pkg::*; #(
   parameter int unsigned           NUM_KEYS      = 5,
   parameter logic [NUM_KEYS*9-1:0] KEYMAP        = {KC_ENTER, KC_D, KC_S, KC_A, KC_W},
   parameter int unsigned           FIFO_DEPTH    = 8,
   parameter int unsigned           REPEAT_DELAY  = 50_000_000,
   parameter int unsigned           REPEAT_PERIOD = 10_000_000,
   localparam int unsigned          KW            = key_width(NUM_KEYS),
   localparam int unsigned          CW            = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                code_valid,
   input  logic [8:0]          code,
   input  logic                code_break,
   input  logic                repeat_en,
   input  logic                evt_ready,
   output logic                evt_valid,
   output logic [KW-1:0]       evt_key,
   output logic                evt_press,
   output logic                evt_repeat,
   output logic [NUM_KEYS-1:0] held,
   output logic [CW-1:0]       fifo_count,
   output logic                overflow,
   input  logic                ovf_clr
);

   localparam int unsigned EW = KW + 2;

   logic [NUM_KEYS-1:0] held_q, held_d;
   logic [KW-1:0]       tgt_q, tgt_d;
   logic                tgt_vld_q, tgt_vld_d;
   rpt_state_e          st_q, st_d;
   logic [31:0]         cnt_q, cnt_d;
   logic                ovf_q, ovf_d;

   logic                hit;
   logic [KW-1:0]       hit_key;
   logic                hit_held, new_make, release_k, code_push, rpt_push;
   logic                push, pop, fifo_full, fifo_empty;
   logic [EW-1:0]       push_data, head;

   // Scan from the top so the lowest matching index is the one left standing.
   always_comb begin
      hit     = 1'b0;
      hit_key = '0;
      for (int i = int'(NUM_KEYS) - 1; i >= 0; i--) begin
         if (code == KEYMAP[9*i +: 9]) begin
            hit     = 1'b1;
            hit_key = KW'(i);
         end
      end
   end

   assign hit_held  = held_q[hit_key];
   assign new_make  = code_valid & hit & ~code_break & ~hit_held;
   assign release_k = code_valid & hit &  code_break &  hit_held;
   assign code_push = new_make | release_k;

   always_comb begin
      held_d    = held_q;
      tgt_d     = tgt_q;
      tgt_vld_d = tgt_vld_q;
      if (new_make) begin
         held_d[hit_key] = 1'b1;
         tgt_d           = hit_key;
         tgt_vld_d       = 1'b1;
      end else if (release_k) begin
         held_d[hit_key] = 1'b0;
         if (hit_key == tgt_q) tgt_vld_d = 1'b0;
      end
   end

   // Repeat fires when the counter would reach 0; if a code event owns the
   // push slot that cycle, the counter parks at 0 and fires on the next free cycle.
   always_comb begin
      st_d     = st_q;
      cnt_d    = cnt_q;
      rpt_push = 1'b0;
      if (!repeat_en) begin
         st_d = StIdle;
      end else if (new_make) begin
         st_d  = StDelay;
         cnt_d = REPEAT_DELAY;
      end else if (!tgt_vld_d) begin
         st_d = StIdle;
      end else begin
         case (st_q)
            StDelay, StPeriod: begin
               if (cnt_q <= 32'd1) begin
                  if (code_push) begin
                     cnt_d = '0;
                  end else begin
                     rpt_push = 1'b1;
                     cnt_d    = REPEAT_PERIOD;
                     st_d     = StPeriod;
                  end
               end else begin
                  cnt_d = cnt_q - 32'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign push      = code_push | rpt_push;
   assign push_data = code_push ? {hit_key, ~code_break, 1'b0} : {tgt_q, 1'b1, 1'b1};
   assign pop       = evt_valid & evt_ready;
   assign ovf_d     = (ovf_q & ~ovf_clr) | (push & fifo_full & ~pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         held_q    <= '0;
         tgt_q     <= '0;
         tgt_vld_q <= 1'b0;
         st_q      <= StIdle;
         cnt_q     <= '0;
         ovf_q     <= 1'b0;
      end else begin
         held_q    <= held_d;
         tgt_q     <= tgt_d;
         tgt_vld_q <= tgt_vld_d;
         st_q      <= st_d;
         cnt_q     <= cnt_d;
         ovf_q     <= ovf_d;
      end
   end

   kb_event_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .head      (head),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // Head fields are forced to zero while empty so stale storage never shows.
   assign evt_valid  = ~fifo_empty;
   assign evt_key    = evt_valid ? head[EW-1:EVT_KEY_LSB] : '0;
   assign evt_press  = evt_valid & head[EVT_PRESS_BIT];
   assign evt_repeat = evt_valid & head[EVT_REPEAT_BIT];
   assign held       = held_q;
   assign overflow   = ovf_q;

endmodule

// File: tb/tb_kb_event_unit.sv
module tb_kb_event_unit;

   logic       clk = 1'b0, rst = 1'b1;
   logic       code_valid = 1'b0, code_break = 1'b0, repeat_en = 1'b0;
   logic       evt_ready = 1'b0, ovf_clr = 1'b0;
   logic [8:0] code = '0;
   logic       evt_valid, evt_press, evt_repeat, overflow;
   logic [2:0] evt_key, fifo_count;
   logic [4:0] held;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   always #5 clk = ~clk;

   kb_event_unit #(
      .NUM_KEYS      (5),
      .FIFO_DEPTH    (4),
      .REPEAT_DELAY  (20),
      .REPEAT_PERIOD (5)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .code_valid (code_valid),
      .code       (code),
      .code_break (code_break),
      .repeat_en  (repeat_en),
      .evt_ready  (evt_ready),
      .evt_valid  (evt_valid),
      .evt_key    (evt_key),
      .evt_press  (evt_press),
      .evt_repeat (evt_repeat),
      .held       (held),
      .fifo_count (fifo_count),
      .overflow   (overflow),
      .ovf_clr    (ovf_clr)
   );

   always @(posedge clk) cyc <= cyc + 1;

   // Log of consumed events, stamped with the cycle in which they were accepted.
   typedef struct {int c; int key; int press; int rpt;} log_t;
   log_t evlog[$];
   always @(negedge clk) begin
      if (!rst && evt_valid && evt_ready)
         evlog.push_back('{cyc, int'(evt_key), int'(evt_press), int'(evt_repeat)});
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [14:0] outs();
      return {evt_valid, evt_key, evt_press, evt_repeat, held, fifo_count, overflow};
   endfunction

   function automatic logic [14:0] mk(logic v, logic [2:0] k, logic p, logic r,
                                      logic [4:0] h, logic [2:0] n, logic o);
      return {v, k, p, r, h, n, o};
   endfunction

   task automatic send(logic [8:0] c, logic brk);
      code = c; code_break = brk; code_valid = 1'b1;
      tick();
      code_valid = 1'b0; code_break = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1; code_valid = 1'b0; ovf_clr = 1'b0;
      tick(); tick();
      rst = 1'b0;
      tick();
      evlog.delete();
   endtask

   task automatic chk_ev(string name, int idx, int ecyc, int ekey, int epress, int erpt);
      if (idx >= evlog.size()) begin
         chk({name, " present"}, 32'(evlog.size()), 32'(idx + 1));
      end else begin
         chk({name, " cycle"}, 32'(evlog[idx].c), 32'(ecyc));
         chk({name, " {key,press,rpt}"},
             32'(evlog[idx].key * 4 + evlog[idx].press * 2 + evlog[idx].rpt),
             32'(ekey * 4 + epress * 2 + erpt));
      end
   endtask

   typedef struct {
      logic        cv;
      logic [8:0]  cd;
      logic        brk;
      logic        rdy;
      logic        clr;
      logic [14:0] exp;
   } vec_t;
   vec_t tbl[18];

   logic [8:0] kc[5] = '{9'h01D, 9'h01C, 9'h01B, 9'h023, 9'h05A};
   logic [8:0] unm[3] = '{9'h015, 9'h11D, 9'h000};

   // Reference model state for the random phase.
   logic [4:0] mq[$];
   logic [4:0] m_held;
   logic       m_ovf;
   bit         r_act;
   int         r_tgt, r_next;

   initial begin
      int t0, t1, n_before;
      // Reset state, sampled while rst is still asserted.
      tick(); tick();
      chk("reset outputs", 32'(outs()), 32'(15'd0));
      rst = 1'b0;
      tick();

      // Table: mapping, typematic resend, unmapped code, overflow, full push+pop.
      tbl[0]  = '{1'b0, 9'h000, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 5'b00000, 0, 0)};
      tbl[1]  = '{1'b1, 9'h01D, 1'b0, 1'b0, 1'b0, mk(1, 0, 1, 0, 5'b00001, 1, 0)};
      tbl[2]  = '{1'b1, 9'h01C, 1'b0, 1'b0, 1'b0, mk(1, 0, 1, 0, 5'b00011, 2, 0)};
      tbl[3]  = '{1'b1, 9'h01D, 1'b0, 1'b0, 1'b0, mk(1, 0, 1, 0, 5'b00011, 2, 0)};
      tbl[4]  = '{1'b1, 9'h01D, 1'b1, 1'b0, 1'b0, mk(1, 0, 1, 0, 5'b00010, 3, 0)};
      tbl[5]  = '{1'b1, 9'h015, 1'b0, 1'b0, 1'b0, mk(1, 0, 1, 0, 5'b00010, 3, 0)};
      tbl[6]  = '{1'b1, 9'h023, 1'b0, 1'b0, 1'b0, mk(1, 0, 1, 0, 5'b01010, 4, 0)};
      tbl[7]  = '{1'b1, 9'h05A, 1'b0, 1'b0, 1'b0, mk(1, 0, 1, 0, 5'b11010, 4, 1)};
      tbl[8]  = '{1'b1, 9'h01C, 1'b1, 1'b0, 1'b0, mk(1, 0, 1, 0, 5'b11000, 4, 1)};
      tbl[9]  = '{1'b0, 9'h000, 1'b0, 1'b0, 1'b1, mk(1, 0, 1, 0, 5'b11000, 4, 0)};
      tbl[10] = '{1'b1, 9'h01B, 1'b0, 1'b1, 1'b0, mk(1, 1, 1, 0, 5'b11100, 4, 0)};
      tbl[11] = '{1'b1, 9'h01B, 1'b1, 1'b0, 1'b1, mk(1, 1, 1, 0, 5'b11000, 4, 1)};
      tbl[12] = '{1'b0, 9'h000, 1'b0, 1'b1, 1'b0, mk(1, 0, 0, 0, 5'b11000, 3, 1)};
      tbl[13] = '{1'b0, 9'h000, 1'b0, 1'b1, 1'b0, mk(1, 3, 1, 0, 5'b11000, 2, 1)};
      tbl[14] = '{1'b0, 9'h000, 1'b0, 1'b1, 1'b0, mk(1, 2, 1, 0, 5'b11000, 1, 1)};
      tbl[15] = '{1'b0, 9'h000, 1'b0, 1'b1, 1'b0, mk(0, 0, 0, 0, 5'b11000, 0, 1)};
      tbl[16] = '{1'b0, 9'h000, 1'b0, 1'b1, 1'b0, mk(0, 0, 0, 0, 5'b11000, 0, 1)};
      tbl[17] = '{1'b0, 9'h000, 1'b0, 1'b1, 1'b1, mk(0, 0, 0, 0, 5'b11000, 0, 0)};
      repeat_en = 1'b0;
      for (int i = 0; i < 18; i++) begin
         code_valid = tbl[i].cv; code = tbl[i].cd; code_break = tbl[i].brk;
         evt_ready = tbl[i].rdy; ovf_clr = tbl[i].clr;
         tick();
         chk($sformatf("table row %0d", i), 32'(outs()), 32'(tbl[i].exp));
      end
      code_valid = 1'b0; ovf_clr = 1'b0;

      // Press then release ten cycles later.
      repeat_en = 1'b1; evt_ready = 1'b1;
      do_reset();
      t0 = cyc;
      send(9'h01D, 1'b0);
      chk("press visible", 32'(outs()), 32'(mk(1, 0, 1, 0, 5'b00001, 1, 0)));
      repeat (9) tick();
      send(9'h01D, 1'b1);
      chk("release held", 32'(held), 32'(5'b00000));
      repeat (3) tick();
      chk_ev("W press", 0, t0 + 1, 0, 1, 0);
      chk_ev("W release", 1, t0 + 11, 0, 0, 0);
      chk("W event count", 32'(evlog.size()), 32'd2);

      // Hold D for 40 cycles: repeats at +20, +25, +30, +35, break stops them.
      do_reset();
      t0 = cyc;
      send(9'h023, 1'b0);
      repeat (39) tick();
      send(9'h023, 1'b1);
      repeat (30) tick();
      chk_ev("D press", 0, t0 + 1, 3, 1, 0);
      for (int i = 0; i < 4; i++)
         chk_ev($sformatf("D repeat %0d", i), 1 + i, t0 + 21 + 5 * i, 3, 1, 1);
      chk_ev("D release", 5, t0 + 41, 3, 0, 0);
      chk("D event count", 32'(evlog.size()), 32'd6);

      // Typematic resends ignored; newest make becomes the repeat target.
      do_reset();
      t0 = cyc;
      repeat (4) send(9'h01D, 1'b0);
      t1 = cyc;
      send(9'h01C, 1'b0);
      chk("retarget held", 32'(held), 32'(5'b00011));
      repeat (23) tick();
      chk_ev("resend W press", 0, t0 + 1, 0, 1, 0);
      chk_ev("resend A press", 1, t1 + 1, 1, 1, 0);
      chk_ev("A repeat", 2, t1 + 21, 1, 1, 1);
      chk("resend event count", 32'(evlog.size()), 32'd3);

      // Repeat due in the same cycle as a code event is pushed one cycle late.
      do_reset();
      t0 = cyc;
      send(9'h01D, 1'b0);
      t1 = cyc;
      send(9'h023, 1'b0);
      repeat (19) tick();
      send(9'h01D, 1'b1);
      repeat (10) tick();
      chk_ev("conflict W press", 0, t0 + 1, 0, 1, 0);
      chk_ev("conflict D press", 1, t1 + 1, 3, 1, 0);
      chk_ev("conflict W release", 2, t1 + 21, 0, 0, 0);
      chk_ev("conflict late repeat", 3, t1 + 22, 3, 1, 1);
      chk_ev("conflict next repeat", 4, t1 + 27, 3, 1, 1);
      chk("conflict event count", 32'(evlog.size()), 32'd5);

      // Reset in the middle of repeating.
      do_reset();
      send(9'h01D, 1'b0);
      repeat (25) tick();
      n_before = evlog.size();
      #2 rst = 1'b1;
      #1 chk("mid reset outputs", 32'(outs()), 32'(15'd0));
      tick();
      rst = 1'b0;
      repeat (40) tick();
      chk("post reset outputs", 32'(outs()), 32'(15'd0));
      chk("no repeats after reset", 32'(evlog.size()), 32'(n_before));
      chk("repeat before reset", 32'(n_before), 32'd2);

      // Random traffic against the reference model.
      do_reset();
      mq.delete(); m_held = '0; m_ovf = 1'b0; r_act = 0; r_tgt = 0; r_next = 0;
      repeat_en = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         int k, vprob, rprob;
         bit cpush, rpush, pop, full, drop;
         logic [4:0] cev, pev;
         logic [14:0] exp;
         vprob = ((c / 250) % 2 == 0) ? 3 : 14;
         rprob = ((c / 200) % 2 == 0) ? 90 : 25;
         code_valid = ($urandom_range(vprob - 1) == 0);
         code = ($urandom_range(7) < 6) ? kc[$urandom_range(4)] : unm[$urandom_range(2)];
         code_break = $urandom_range(1);
         evt_ready = ($urandom_range(99) < rprob);
         ovf_clr = ($urandom_range(15) == 0);
         if ($urandom_range(63) == 0) repeat_en = ~repeat_en;

         k = -1;
         if (code_valid)
            for (int i = 0; i < 5; i++)
               if (k < 0 && code == kc[i]) k = i;
         cpush = 0; cev = '0;
         if (k >= 0) begin
            if (!code_break && !m_held[k]) begin
               m_held[k] = 1'b1; cpush = 1; cev = {3'(k), 2'b10};
               r_tgt = k;
               if (repeat_en) begin r_act = 1; r_next = c + 20; end
            end else if (code_break && m_held[k]) begin
               m_held[k] = 1'b0; cpush = 1; cev = {3'(k), 2'b00};
               if (k == r_tgt) r_act = 0;
            end
         end
         if (!repeat_en) r_act = 0;
         rpush = 0;
         if (r_act && c >= r_next && !cpush) begin
            rpush = 1; r_next = c + 5;
         end
         pev = cpush ? cev : {3'(r_tgt), 2'b11};
         pop = (mq.size() > 0) && evt_ready;
         full = (mq.size() == 4);
         if (pop) void'(mq.pop_front());
         drop = 0;
         if (cpush || rpush) begin
            if (full && !pop) drop = 1;
            else mq.push_back(pev);
         end
         m_ovf = (m_ovf && !ovf_clr) || drop;

         tick();
         exp = {mq.size() > 0, (mq.size() > 0) ? mq[0] : 5'd0, m_held, 3'(mq.size()), m_ovf};
         chk($sformatf("random cycle %0d", c), 32'(outs()), 32'(exp));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
